// File: rtl/vga_rect_fill.sv
// vga_rect_fill
//    Fills an axis-aligned rectangle (start) or the whole active screen (clear)
//    by streaming one pixel write per clock to a VGA adapter, in raster order.
//    The rectangle is clipped to the active area of the latched resolution.
//
// Ports
//    CLOCK_50              sole clock, rising edge
//    reset                 synchronous, active-high
//    start, clear          command requests, sampled only in IDLE; clear wins
//    res_mode              0 = 160x120, 1 = 320x240
//    x0, y0, w, h          rectangle top-left and size for start
//    colour_in             fill colour for start
//    x, y, colour, writeEn registered pixel-write bus
//    busy                  command in progress (LOAD/DRAW)
//    done                  one-cycle completion pulse
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start/clear; command inputs latched on accept
// LOAD  | clip against the screen, set up the first pixel or skip
// DRAW  | one pixel per cycle, x fastest, then y
// DONE  | done pulse, back to IDLE

module vga_rect_fill #(
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic       clear,
   input  logic       res_mode,
   input  logic [8:0] x0,
   input  logic [7:0] y0,
   input  logic [8:0] w,
   input  logic [7:0] h,
   input  logic [2:0] colour_in,
   output logic [8:0] x,
   output logic [7:0] y,
   output logic [2:0] colour,
   output logic       writeEn,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DRAW = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0] state;

   logic [8:0] cmd_x0;
   logic [7:0] cmd_y0;
   logic [8:0] cmd_w;
   logic [7:0] cmd_h;
   logic [2:0] cmd_col;
   logic       cmd_mode;

   logic [8:0] x_end;
   logic [7:0] y_end;

   // Clipping is done in 10 bits so that x0 + w and similar sums never wrap.
   logic [9:0] x_lim;
   logic [9:0] y_lim;
   logic [9:0] x0_10;
   logic [9:0] y0_10;
   logic [9:0] w_10;
   logic [9:0] h_10;
   logic [9:0] x_room;
   logic [9:0] y_room;
   logic [9:0] eff_w;
   logic [9:0] eff_h;
   logic       empty;

   always_comb begin
      x_lim  = cmd_mode ? 10'd320 : 10'd160;
      y_lim  = cmd_mode ? 10'd240 : 10'd120;
      x0_10  = {1'b0, cmd_x0};
      y0_10  = {2'b00, cmd_y0};
      w_10   = {1'b0, cmd_w};
      h_10   = {2'b00, cmd_h};
      empty  = (cmd_w == 9'd0) || (cmd_h == 8'd0) || (x0_10 >= x_lim) || (y0_10 >= y_lim);
      // room values are only meaningful when not empty
      x_room = x_lim - x0_10;
      y_room = y_lim - y0_10;
      eff_w  = (w_10 < x_room) ? w_10 : x_room;
      eff_h  = (h_10 < y_room) ? h_10 : y_room;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state    <= S_IDLE;
         x        <= '0;
         y        <= '0;
         colour   <= '0;
         writeEn  <= 1'b0;
         cmd_x0   <= '0;
         cmd_y0   <= '0;
         cmd_w    <= '0;
         cmd_h    <= '0;
         cmd_col  <= '0;
         cmd_mode <= 1'b0;
         x_end    <= '0;
         y_end    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               writeEn <= 1'b0;
               if (clear) begin
                  cmd_x0   <= '0;
                  cmd_y0   <= '0;
                  cmd_w    <= res_mode ? 9'd320 : 9'd160;
                  cmd_h    <= res_mode ? 8'd240 : 8'd120;
                  cmd_col  <= BG_COLOUR;
                  cmd_mode <= res_mode;
                  state    <= S_LOAD;
               end else if (start) begin
                  cmd_x0   <= x0;
                  cmd_y0   <= y0;
                  cmd_w    <= w;
                  cmd_h    <= h;
                  cmd_col  <= colour_in;
                  cmd_mode <= res_mode;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (empty) begin
                  state <= S_DONE;
               end else begin
                  x       <= cmd_x0;
                  y       <= cmd_y0;
                  colour  <= cmd_col;
                  writeEn <= 1'b1;
                  // last pixel coordinates always fit: they are inside the screen
                  x_end   <= 9'(x0_10 + eff_w - 10'd1);
                  y_end   <= 8'(y0_10 + eff_h - 10'd1);
                  state   <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (x == x_end) begin
                  if (y == y_end) begin
                     writeEn <= 1'b0;
                     state   <= S_DONE;
                  end else begin
                     x <= cmd_x0;
                     y <= y + 8'd1;
                  end
               end else begin
                  x <= x + 9'd1;
               end
            end
            S_DONE: begin
               writeEn <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               writeEn <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = (state == S_LOAD) || (state == S_DRAW);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_vga_rect_fill.sv
module tb_vga_rect_fill;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       clear;
   logic       res_mode;
   logic [8:0] x0;
   logic [7:0] y0;
   logic [8:0] w;
   logic [7:0] h;
   logic [2:0] colour_in;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] colour;
   logic       writeEn;
   logic       busy;
   logic       done;

   vga_rect_fill dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .start    (start),
      .clear    (clear),
      .res_mode (res_mode),
      .x0       (x0),
      .y0       (y0),
      .w        (w),
      .h        (h),
      .colour_in(colour_in),
      .x        (x),
      .y        (y),
      .colour   (colour),
      .writeEn  (writeEn),
      .busy     (busy),
      .done     (done)
   );

   always #10 clk = ~clk;

   // cycle k is the interval ending at the k-th rising edge after time 0
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit is_done;
      int px;
      int py;
      int col;
      int at;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   exp_t m;
   always @(negedge clk) begin
      if (writeEn) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got (%0d,%0d) c=%0d at cycle %0d, required none", x, y, colour, cyc);
         end else begin
            m = sb.pop_front();
            if (m.is_done || int'(x) != m.px || int'(y) != m.py || int'(colour) != m.col
                || cyc != m.at || !busy) begin
               errors++;
               $display("FAIL pixel got (%0d,%0d) c=%0d busy=%0d at %0d, required done=%0d (%0d,%0d) c=%0d busy=1 at %0d",
                        x, y, colour, busy, cyc, m.is_done, m.px, m.py, m.col, m.at);
            end
         end
      end
      if (done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done at cycle %0d, required none", cyc);
         end else begin
            m = sb.pop_front();
            if (!m.is_done || cyc != m.at || busy) begin
               errors++;
               $display("FAIL done got done at %0d busy=%0d, required done=%0d at %0d busy=0",
                        cyc, busy, m.is_done, m.at);
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, req);
      end
   endtask

   task automatic push_rect(input int n, input int ex0, input int ey0, input int ew, input int eh,
                            input int ecol, input bit with_done);
      exp_t e;
      for (int r = 0; r < eh; r++)
         for (int c = 0; c < ew; c++) begin
            e.is_done = 1'b0;
            e.px = ex0 + c;
            e.py = ey0 + r;
            e.col = ecol;
            e.at = n + 2 + r * ew + c;
            sb.push_back(e);
         end
      if (with_done) begin
         e.is_done = 1'b1;
         e.px = 0;
         e.py = 0;
         e.col = 0;
         e.at = n + 2 + ew * eh;
         sb.push_back(e);
      end
   endtask

   // Called at a falling edge while the DUT is IDLE; the command is accepted at
   // the next rising edge. Expected clipped geometry is supplied by the caller.
   task automatic run_cmd(input bit st, input bit cl, input bit md,
                          input int ix0, input int iy0, input int iw, input int ih, input int ic,
                          input int ex0, input int ey0, input int ew, input int eh, input int ecol,
                          input int mid);
      int n;
      int lim;
      n = cyc;
      start = st;
      clear = cl;
      res_mode = md;
      x0 = 9'(ix0);
      y0 = 8'(iy0);
      w = 9'(iw);
      h = 8'(ih);
      colour_in = 3'(ic);
      push_rect(n, ex0, ey0, ew, eh, ecol, 1'b1);
      @(negedge clk);
      start = 1'b0;
      clear = 1'b0;
      res_mode = ~md;
      x0 = 9'($urandom);
      y0 = 8'($urandom);
      w = 9'($urandom);
      h = 8'($urandom);
      colour_in = 3'($urandom);
      lim = ew * eh + 20;
      for (int i = 0; i < lim && sb.size() > 0; i++) begin
         start = (mid > 0 && i == mid);
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL timeout pending %0d expected events after %0d cycles, required 0", sb.size(), lim);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      clear = 1'b0;
      res_mode = 1'b0;
      x0 = '0;
      y0 = '0;
      w = '0;
      h = '0;
      colour_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_x", int'(x), 0);
      chk("reset_y", int'(y), 0);
      chk("reset_colour", int'(colour), 0);
      chk("reset_writeEn", int'(writeEn), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      reset = 1'b0;

      // 3x2 basic fill, accepted in the first cycle after reset
      run_cmd(1, 0, 0, 10, 20, 3, 2, 3'b100, 10, 20, 3, 2, 4, 0);
      // clipped at the bottom-right corner, 160x120
      run_cmd(1, 0, 0, 158, 118, 5, 5, 3'b010, 158, 118, 2, 2, 2, 0);
      // empty commands
      run_cmd(1, 0, 0, 5, 5, 0, 3, 3'b001, 0, 0, 0, 0, 0, 0);
      run_cmd(1, 0, 0, 200, 5, 4, 4, 3'b001, 0, 0, 0, 0, 0, 0);
      run_cmd(1, 0, 0, 160, 5, 1, 1, 3'b001, 0, 0, 0, 0, 0, 0);
      run_cmd(1, 0, 0, 5, 120, 1, 1, 3'b001, 0, 0, 0, 0, 0, 0);
      run_cmd(1, 0, 0, 5, 5, 4, 0, 3'b001, 0, 0, 0, 0, 0, 0);
      // single last pixel, 160x120
      run_cmd(1, 0, 0, 159, 119, 1, 1, 3'b110, 159, 119, 1, 1, 6, 0);
      // 320x240 clipping and a wide unclipped block
      run_cmd(1, 0, 1, 318, 238, 5, 5, 3'b011, 318, 238, 2, 2, 3, 0);
      run_cmd(1, 0, 1, 200, 200, 50, 10, 3'b111, 200, 200, 50, 10, 7, 0);
      // x0 valid in 320 mode but beyond 160 mode
      run_cmd(1, 0, 1, 200, 100, 2, 1, 3'b101, 200, 100, 2, 1, 5, 0);

      // reset on the 4th write of a 10x10 fill aborts it without a done pulse
      begin
         int n;
         n = cyc;
         start = 1'b1;
         res_mode = 1'b0;
         x0 = 9'd50;
         y0 = 8'd50;
         w = 9'd10;
         h = 8'd10;
         colour_in = 3'b101;
         push_rect(n, 50, 50, 4, 1, 5, 1'b0);
         @(negedge clk);
         start = 1'b0;
         repeat (4) @(negedge clk);
         chk("abort_4th_write_present", int'(writeEn), 1);
         reset = 1'b1;
         @(negedge clk);
         chk("abort_writeEn", int'(writeEn), 0);
         chk("abort_x", int'(x), 0);
         chk("abort_y", int'(y), 0);
         chk("abort_colour", int'(colour), 0);
         chk("abort_busy", int'(busy), 0);
         chk("abort_done", int'(done), 0);
         chk("abort_pending", sb.size(), 0);
         sb.delete();
         reset = 1'b0;
         run_cmd(1, 0, 0, 1, 2, 2, 2, 3'b011, 1, 2, 2, 2, 3, 0);
      end

      // start and clear together: clear wins, full 320x240; start mid-DRAW ignored
      run_cmd(1, 1, 1, 3, 4, 5, 6, 3'b111, 0, 0, 320, 240, 0, 100);

      repeat (5) @(negedge clk);
      chk("final_pending", sb.size(), 0);
      chk("final_busy", int'(busy), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_rect_fill.md
VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 SHALL have parameter BG_COLOUR, default 3'b000, colour used by the clear command.
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to fill the rectangle described by x0/y0/w/h/colour_in.
REQ-005 SHALL have port clear  input  1  request to fill the whole active screen with BG_COLOUR.
REQ-006 SHALL have port res_mode  input  1  0 = 160x120, 1 = 320x240; same encoding as vga_resolution_mode.
REQ-007 SHALL have ports x0  input  9  and y0  input  8, giving the rectangle top-left pixel.
REQ-008 SHALL have ports w  input  9  and h  input  8, giving the rectangle width and height in pixels.
REQ-009 SHALL have port colour_in  input  3  fill colour for start.
REQ-010 SHALL have ports x  output  9,  y  output  8,  colour  output  3,  writeEn  output  1, forming the pixel-write bus to the VGA adapter.
REQ-011 SHALL have ports busy  output  1  (command in progress) and done  output  1  (one-cycle completion pulse).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, DRAW, DONE.
REQ-013 IDLE: sample clear/start each cycle; clear has priority when both are high; accepted command -> LOAD; otherwise stay in IDLE.
REQ-014 SHALL latch all command inputs and res_mode at acceptance; input changes after acceptance have no effect.
REQ-015 Clear SHALL resolve to x0=0, y0=0, w=XMAX+1, h=YMAX+1, colour=BG_COLOUR.
REQ-016 XMAX/YMAX SHALL be 159/119 when the latched res_mode=0, and 319/239 when res_mode=1.
REQ-017 LOAD SHALL clip: effective W = min(w, XMAX+1-x0), effective H = min(h, YMAX+1-y0), with 10-bit internal arithmetic so that no intermediate value wraps.
REQ-018 LOAD SHALL go to DONE, with zero writes, if w=0, h=0, x0>XMAX or y0>YMAX; otherwise it SHALL go to DRAW.
REQ-019 DRAW SHALL emit exactly one pixel per cycle, with writeEn=1, in raster order: x increments first from x0 to x0+W-1, then y increments.
REQ-020 DRAW SHALL go to DONE on the cycle after the pixel (x0+W-1, y0+H-1) is presented.
REQ-021 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-022 Outputs x/y/colour/writeEn SHALL be registered; writeEn=1 only in DRAW.
REQ-023 In non-DRAW states, x/y/colour SHALL hold their last values and writeEn SHALL be 0.
REQ-024 busy SHALL be 1 in LOAD and DRAW, and 0 in IDLE and DONE.
REQ-025 start/clear asserted while not in IDLE SHALL be ignored (not queued).
REQ-026 Timing: with a command accepted at the edge ending cycle N, the first pixel has writeEn=1 in cycle N+2.
REQ-027 Timing: the last pixel appears in cycle N+1+W*H, done in cycle N+2+W*H, and the earliest next acceptance is in cycle N+3+W*H.
REQ-028 Empty command timing: done in cycle N+2, with no writeEn pulse.
REQ-029 Writes SHALL never address x>XMAX or y>YMAX for the latched mode.

Reset
REQ-030 While reset=1 at a clock edge: state<=IDLE; x=0, y=0, colour=0, writeEn=0, busy=0, done=0.
REQ-031 Reset SHALL take priority over all commands.
REQ-032 Reset mid-DRAW SHALL abort the command: writeEn=0 from the cycle after the reset edge, with no done pulse.
REQ-033 After reset deasserts, the block SHALL accept a command in the first IDLE cycle.

Verification
REQ-034 Scenario: res_mode=0, start with x0=10, y0=20, w=3, h=2, colour_in=3'b100 -> 6 writes (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), colour 100, first write 2 cycles after acceptance, done 1 cycle after last write.
REQ-035 Scenario: res_mode=0, start with x0=158, y0=118, w=5, h=5 -> clipped to 2x2: writes (158,118)(159,118)(158,119)(159,119) only.
REQ-036 Scenario: res_mode=1, clear with BG_COLOUR=3'b000 -> 76800 writes covering (0,0)..(319,239) in raster order, busy high throughout, single done pulse.
REQ-037 Scenario: start with w=0, and separately with x0=200 under res_mode=0 -> no writeEn, done in cycle N+2.
REQ-038 Scenario: start and clear asserted in the same cycle; then start pulsed again mid-DRAW -> clear executes, and the second start produces no extra writes.
REQ-039 Scenario: reset asserted on the 4th write of a 10x10 fill -> writeEn=0 next cycle, all outputs 0, no done, and a new start is accepted after reset drops.
